alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Upstream issue stage for the 16-bit alu: holds an 8-entry x16 register file, accepts one
//  instruction (op, ra, rb, rd) via valid/ready, drives alu A/B/select, captures alu out/z_flag,
//  and writes the result back to R[rd] with a sticky zero flag. 3-state FSM, one instr per 3 cycles.
// PARAMETERS
//  WIDTH   16  datapath width (matches alu A/B/out)
//  NREGS   8   register-file entries (address width clog2(NREGS)=3)
// PORTS
//  clk          in   1   system clock, all state on posedge
//  rst          in   1   asynchronous, active-high reset
//  instr_valid  in   1   instruction request
//  instr_ready  out  1   issue accepts instruction this cycle
//  instr_op     in   3   alu select code
//  instr_ra     in   3   source register driven on alu A
//  instr_rb     in   3   source register driven on alu B
//  instr_rd     in   3   destination register
//  ld_en        in   1   direct register load strobe
//  ld_addr      in   3   load address
//  ld_data      in   16  load data
//  dbg_addr     in   3   debug read address
//  dbg_data     out  16  R[dbg_addr], combinational
//  alu_a        out  16  to alu A (registered)
//  alu_b        out  16  to alu B (registered)
//  alu_sel      out  3   to alu select (registered)
//  alu_out      in   16  from alu out
//  alu_z        in   1   from alu z_flag
//  z_reg        out  1   zero flag of last written result
//  done         out  1   one-cycle pulse: instruction retired
//  err          out  1   one-cycle pulse: illegal op retired without writeback
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, all R[i]=0, alu_a=alu_b=0, alu_sel=3'b011, z_reg=0,
//    done=0, err=0. Reset mid-instruction aborts it: no writeback, no done/err.
//  - alu op codes: 000 A+B, 001 B-A, 010 A*B (low 16 bits), 011 pass A, 100 pass B;
//    101..111 illegal. All arithmetic modulo 2^16.
//  - instr_ready = (state==IDLE) && !ld_en.
//  - IDLE: ld_en -> R[ld_addr]<=ld_data. Else instr_valid -> latch op/rd, alu_a<=R[ra],
//    alu_b<=R[rb], alu_sel<=op, go EXEC. Operands read at accept; rd==ra/rb safe.
//  - EXEC (1 cycle): alu treated as combinational; at edge, capture alu_out/alu_z -> res/resz; go WB.
//  - WB: at edge, legal op: R[rd]<=res, z_reg<=resz, done<=1. Illegal op: R, z_reg unchanged,
//    err<=1, done<=0. Go IDLE. done/err high exactly one cycle (cycle after WB edge).
//  - Latency: accept at edge N; result visible in R[rd] and done high after edge N+2.
//    Next accept possible at edge N+3 (done cycle overlaps IDLE; ready may be high with done).
//  - ld_en outside IDLE is ignored (no write). Simultaneous ld_en and instr_valid in IDLE: load
//    wins, instruction held off; next cycle it is accepted and reads the newly loaded value.
//  - dbg_data reflects writes the cycle after the write edge.
//  - alu_a/alu_b/alu_sel hold their last values in IDLE and WB (no toggling).
// TESTING
//  1. Load R1=60,R2=62; issue op000 ra=1 rb=2 rd=3 -> done 3 cycles after accept, R3=122, z_reg=0.
//  2. Load R1=40,R2=40; op001 ra=1 rb=2 rd=4 -> R4=0, z_reg=1; then R1=20,R2=40 -> R4=20, z_reg=0.
//  3. R1=40,R2=40 op010 rd=5 -> R5=1600; R1=R2=300 op010 -> R5=90000 mod 65536=24464.
//  4. op101 rd=3 with R3=122, z_reg=0 -> err pulse 1 cycle, done=0, R3=122, z_reg=0.
//  5. IDLE, ld_en(R1=7)+instr_valid(op011 ra=1 rd=6) same cycle -> ready=0, accepted next cycle, R6=7.
//  6. Assert rst during EXEC -> immediate IDLE, all R=0, no done; back-to-back R3=R1+R2 then
//     op011 ra=3 rd=4 after reset reload -> R4=122.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// alu_issue_ctrl
//
// Issue stage that sits in front of a 16-bit combinational ALU. It owns an
// 8-entry register file and accepts one instruction (op, ra, rb, rd) over a
// valid/ready handshake. It drives the ALU operands and select from flops,
// captures the ALU result and zero flag, and then writes the result back to
// R[rd]. The zero flag of the last written result is kept in z_reg.
//
// Each instruction passes through three states:
//   IDLE : accept an instruction (or perform a direct register load)
//   EXEC : ALU settles; capture alu_out / alu_z
//   WB   : write R[rd] and z_reg (legal op) or flag err (illegal op)
// so one instruction is issued at most every three cycles.
//
// Handshake: an instruction transfers on a rising clk edge where
// instr_valid && instr_ready. instr_ready is high only in IDLE and only while
// no direct load is requested; a pending load therefore always wins and the
// instruction is taken on a later cycle (seeing the freshly loaded value).
//
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   instr_valid / instr_ready      instruction handshake
//   instr_op, instr_ra/rb/rd       ALU select, source and destination regs
//   ld_en, ld_addr, ld_data        direct register load (honoured in IDLE only)
//   dbg_addr / dbg_data            combinational register-file read port
//   alu_a, alu_b, alu_sel          registered ALU operands and select
//   alu_out, alu_z                 ALU result and zero flag
//   z_reg                          zero flag of the last written result
//   done                           one-cycle pulse: legal instruction retired
//   err                            one-cycle pulse: illegal op retired, no write
// ============================================================================
module alu_issue_ctrl #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [2:0]       instr_op,
    input  logic [2:0]       instr_ra,
    input  logic [2:0]       instr_rb,
    input  logic [2:0]       instr_rd,
    input  logic             ld_en,
    input  logic [2:0]       ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [2:0]       dbg_addr,
    output logic [WIDTH-1:0] dbg_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_z,
    output logic             z_reg,
    output logic             done,
    output logic             err
);

    // ------------------------------------------------------------------
    // ALU select encodings. Codes above OP_PASS_B are illegal.
    // ------------------------------------------------------------------
    localparam logic [2:0] OP_ADD    = 3'b000;  // A + B
    localparam logic [2:0] OP_SUB    = 3'b001;  // B - A
    localparam logic [2:0] OP_MUL    = 3'b010;  // low half of A * B
    localparam logic [2:0] OP_PASS_A = 3'b011;  // A
    localparam logic [2:0] OP_PASS_B = 3'b100;  // B

    // Select value presented to the ALU out of reset: a harmless pass-through.
    localparam logic [2:0] SEL_RESET = OP_PASS_A;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_q,   state_d;
    logic [WIDTH-1:0] regs_q     [NREGS];
    logic [WIDTH-1:0] regs_d     [NREGS];
    logic [WIDTH-1:0] alu_a_q,   alu_a_d;
    logic [WIDTH-1:0] alu_b_q,   alu_b_d;
    logic [2:0]       alu_sel_q, alu_sel_d;
    logic [2:0]       op_q,      op_d;
    logic [2:0]       rd_q,      rd_d;
    logic [WIDTH-1:0] res_q,     res_d;
    logic             resz_q,    resz_d;
    logic             z_reg_q,   z_reg_d;
    logic             done_q,    done_d;
    logic             err_q,     err_d;

    logic             op_legal;

    // Only the five defined select codes produce a writeback.
    always_comb begin
        op_legal = 1'b0;
        case (op_q)
            OP_ADD, OP_SUB, OP_MUL, OP_PASS_A, OP_PASS_B: op_legal = 1'b1;
            default:                                      op_legal = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        regs_d    = regs_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        op_d      = op_q;
        rd_d      = rd_q;
        res_d     = res_q;
        resz_d    = resz_q;
        z_reg_d   = z_reg_q;
        // done / err are pulses: they fall back to zero unless set below.
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ld_en) begin
                    // Direct load takes priority; any pending instruction
                    // waits and will read this value once accepted.
                    regs_d[ld_addr] = ld_data;
                end else if (instr_valid) begin
                    // Operands are sampled here, so rd may alias ra/rb.
                    op_d      = instr_op;
                    rd_d      = instr_rd;
                    alu_a_d   = regs_q[instr_ra];
                    alu_b_d   = regs_q[instr_rb];
                    alu_sel_d = instr_op;
                    state_d   = ST_EXEC;
                end
            end

            ST_EXEC: begin
                // alu_a/alu_b/alu_sel have been stable for a full cycle.
                res_d   = alu_out;
                resz_d  = alu_z;
                state_d = ST_WB;
            end

            ST_WB: begin
                if (op_legal) begin
                    regs_d[rd_q] = res_q;
                    z_reg_d      = resz_q;
                    done_d       = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers. Reset aborts any instruction in flight: the FSM returns to
    // IDLE with no writeback and no done/err pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            regs_q    <= '{default: '0};
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= SEL_RESET;
            op_q      <= SEL_RESET;
            rd_q      <= '0;
            res_q     <= '0;
            resz_q    <= 1'b0;
            z_reg_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            regs_q    <= regs_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            res_q     <= res_d;
            resz_q    <= resz_d;
            z_reg_q   <= z_reg_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign instr_ready = (state_q == ST_IDLE) && !ld_en;
    assign dbg_data    = regs_q[dbg_addr];
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_sel     = alu_sel_q;
    assign z_reg       = z_reg_q;
    assign done        = done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ============================================================================
// tb_alu_issue_ctrl
//
// Drives alu_issue_ctrl together with a behavioural 16-bit ALU. A reference
// register file (ref_regs / ref_z) is updated in program order as loads and
// instructions are issued; each issued instruction pushes the expected
// retirement (kind, rd, zero flag, R[rd] value, retire cycle) into exp_q.
// An independent monitor pops and compares whenever done or err is seen, and
// performs full register-file sweeps on request.
// ============================================================================
module tb_alu_issue_ctrl;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  instr_op, instr_ra, instr_rb, instr_rd;
    logic        ld_en;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;
    logic [15:0] alu_a, alu_b;
    logic [2:0]  alu_sel;
    logic [15:0] alu_out;
    logic        alu_z;
    logic        z_reg, done, err;

    alu_issue_ctrl #(.WIDTH(16), .NREGS(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_op    (instr_op),
        .instr_ra    (instr_ra),
        .instr_rb    (instr_rb),
        .instr_rd    (instr_rd),
        .ld_en       (ld_en),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_z       (alu_z),
        .z_reg       (z_reg),
        .done        (done),
        .err         (err)
    );

    // Combinational ALU attached to the DUT. Illegal selects give a
    // distinctive non-zero value that must never reach the register file.
    always_comb begin
        case (alu_sel)
            3'd0:    alu_out = alu_a + alu_b;
            3'd1:    alu_out = alu_b - alu_a;
            3'd2:    alu_out = alu_a * alu_b;
            3'd3:    alu_out = alu_a;
            3'd4:    alu_out = alu_b;
            default: alu_out = 16'hDEAD;
        endcase
        alu_z = (alu_out == 16'd0);
    end

    // ------------------------------------------------------------------
    // Reference model and scoreboard
    // ------------------------------------------------------------------
    // entry = {is_err[52], rd[51:49], z[48], data[47:32], retire_cyc[31:0]}
    logic [52:0] exp_q[$];
    longint      ref_regs [8];
    logic        ref_z;

    int n_cmp  = 0;
    int n_fail = 0;

    int sweep_req_id = 0;
    int sweep_cnt    = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: timed out waiting (t=%0t)", name, $time);
    endtask

    // Result of an operation from the ALU's arithmetic definition, mod 2^16.
    function automatic longint model_op(input int op, input longint a, input longint b);
        case (op)
            0:       return (a + b) % 65536;
            1:       return (b - a + 65536) % 65536;
            2:       return (a * b) % 65536;
            3:       return a;
            default: return b;
        endcase
    endfunction

    // Called at the negedge before the accepting edge: retire is 3 edges later.
    task automatic push_expect(input int op, input int ra, input int rb, input int rd);
        longint r;
        logic [52:0] e;
        if (op > 4) begin
            e = {1'b1, 3'(rd), ref_z, 16'(ref_regs[rd]), 32'(cyc + 3)};
        end else begin
            r            = model_op(op, ref_regs[ra], ref_regs[rb]);
            ref_regs[rd] = r;
            ref_z        = (r == 0);
            e = {1'b0, 3'(rd), ref_z, 16'(r), 32'(cyc + 3)};
        end
        exp_q.push_back(e);
    endtask

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic wait_ready(output bit ok);
        int n = 0;
        while (!instr_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        ok = instr_ready;
    endtask

    task automatic load(input int a, input int d);
        bit ok;
        @(negedge clk);
        wait_ready(ok);
        if (!ok) begin
            timeout_fail("load_wait_idle");
            return;
        end
        ld_en   = 1'b1;
        ld_addr = 3'(a);
        ld_data = 16'(d);
        ref_regs[a] = d;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic issue(input int op, input int ra, input int rb, input int rd);
        bit ok;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 3'(op);
        instr_ra    = 3'(ra);
        instr_rb    = 3'(rb);
        instr_rd    = 3'(rd);
        wait_ready(ok);
        if (!ok) begin
            timeout_fail("issue_wait_ready");
            instr_valid = 1'b0;
            return;
        end
        push_expect(op, ra, rb, rd);
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) timeout_fail("drain");
    endtask

    task automatic sweep();
        int n = 0;
        sweep_req_id++;
        while (sweep_cnt != sweep_req_id && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sweep_cnt != sweep_req_id) timeout_fail("sweep");
    endtask

    task automatic reset_outputs_check(input string tag);
        check({tag, "_done"},    done,    0);
        check({tag, "_err"},     err,     0);
        check({tag, "_z_reg"},   z_reg,   0);
        check({tag, "_alu_a"},   alu_a,   0);
        check({tag, "_alu_b"},   alu_b,   0);
        check({tag, "_alu_sel"}, alu_sel, 3);
    endtask

    // ------------------------------------------------------------------
    // Monitor: retirement checks and register sweeps
    // ------------------------------------------------------------------
    initial begin
        logic [52:0] e;
        dbg_addr = 3'd0;
        forever begin
            @(negedge clk);
            if (done || err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_retire", {done, err}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_flag",  done,  !e[52]);
                    check("err_flag",   err,   e[52]);
                    check("retire_cyc", cyc,   e[31:0]);
                    check("z_reg",      z_reg, e[48]);
                    dbg_addr = e[51:49];
                    #1;
                    check("rd_value", dbg_data, e[47:32]);
                end
            end else if (sweep_cnt != sweep_req_id) begin
                for (int a = 0; a < 8; a++) begin
                    dbg_addr = 3'(a);
                    #1;
                    check($sformatf("sweep_R%0d", a), dbg_data, ref_regs[a]);
                end
                sweep_cnt = sweep_req_id;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        bit ok;
        rst         = 1'b1;
        instr_valid = 1'b0;
        instr_op    = 3'd0;
        instr_ra    = 3'd0;
        instr_rb    = 3'd0;
        instr_rd    = 3'd0;
        ld_en       = 1'b0;
        ld_addr     = 3'd0;
        ld_data     = 16'd0;
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        ref_z = 1'b0;

        repeat (3) @(negedge clk);
        reset_outputs_check("reset");
        check("reset_ready", instr_ready, 1);
        rst = 1'b0;
        sweep();

        // Add: 60 + 62 -> 122
        load(1, 60); load(2, 62);
        issue(0, 1, 2, 3);
        // Subtract to zero, then non-zero
        load(1, 40); load(2, 40);
        issue(1, 1, 2, 4);
        load(1, 20);
        issue(1, 1, 2, 4);
        // Multiply, including wrap: 300*300 mod 65536 = 24464
        load(1, 40); load(2, 40);
        issue(2, 1, 2, 5);
        load(1, 300); load(2, 300);
        issue(2, 1, 2, 5);
        // Illegal op: err pulse, R3 and z_reg untouched
        issue(5, 0, 0, 3);
        wait_drain();

        // Load and instruction in the same cycle: load wins, instr waits
        @(negedge clk);
        wait_ready(ok);
        ld_en       = 1'b1;
        ld_addr     = 3'd1;
        ld_data     = 16'd7;
        instr_valid = 1'b1;
        instr_op    = 3'd3;
        instr_ra    = 3'd1;
        instr_rb    = 3'd0;
        instr_rd    = 3'd6;
        ref_regs[1] = 7;
        #1 check("ready_low_during_load", instr_ready, 0);
        @(posedge clk);
        #1 ld_en = 1'b0;
        @(negedge clk);
        check("ready_after_load", instr_ready, 1);
        push_expect(3, 1, 0, 6);
        @(posedge clk);
        #1 instr_valid = 1'b0;

        // Load during EXEC must be ignored
        issue(4, 0, 2, 7);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = 3'd2;
        ld_data = 16'd999;
        @(posedge clk);
        #1 ld_en = 1'b0;
        wait_drain();
        sweep();

        // Reset in EXEC aborts the instruction (no push: nothing may retire)
        @(negedge clk);
        instr_valid = 1'b1;
        instr_op    = 3'd0;
        instr_ra    = 3'd1;
        instr_rb    = 3'd2;
        instr_rd    = 3'd3;
        wait_ready(ok);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 reset_outputs_check("midreset");
        for (int i = 0; i < 8; i++) ref_regs[i] = 0;
        ref_z = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        sweep();

        // Reload, then back-to-back dependent instructions
        load(1, 60); load(2, 62);
        issue(0, 1, 2, 3);
        issue(3, 3, 0, 4);

        // Randomised mix of loads and instructions
        for (int it = 0; it < 80; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 4) begin
                if ($urandom_range(0, 1) == 0)
                    load(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
                else
                    load(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
            end else begin
                issue(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            end
        end
        wait_drain();
        sweep();
        repeat (3) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
